// File: rtl/jtkcpu_pkg.sv
// Shared constants for the KCPU shift unit: condition-code bit positions,
// shift op encodings and the shifter FSM state type.
package jtkcpu_pkg;

    localparam int CC_C_BIT = 0;
    localparam int CC_V_BIT = 1;
    localparam int CC_Z_BIT = 2;
    localparam int CC_N_BIT = 3;

    localparam logic [2:0] SH_ASL = 3'd0;
    localparam logic [2:0] SH_LSR = 3'd1;
    localparam logic [2:0] SH_ASR = 3'd2;
    localparam logic [2:0] SH_ROL = 3'd3;
    localparam logic [2:0] SH_ROR = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } sh_state_t;

endpackage

// File: rtl/jtkcpu_shstep.sv
// One combinational shift/rotate step over {C, r}; V follows the top two bits
// of the incoming word for left shifts and is passed through otherwise.
module jtkcpu_shstep
    import jtkcpu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] r,
    input  logic             c,
    input  logic             v,
    output logic [WIDTH-1:0] r_nxt,
    output logic             c_nxt,
    output logic             v_nxt
);

    always_comb begin
        r_nxt = r;
        c_nxt = c;
        v_nxt = v;
        case (op)
            SH_ASL: begin
                {c_nxt, r_nxt} = {r, 1'b0};
                v_nxt          = r[WIDTH-1] ^ r[WIDTH-2];
            end
            SH_LSR: {r_nxt, c_nxt} = {1'b0, r};
            SH_ASR: {r_nxt, c_nxt} = {r[WIDTH-1], r};
            SH_ROL: begin
                {c_nxt, r_nxt} = {r, c};
                v_nxt          = r[WIDTH-1] ^ r[WIDTH-2];
            end
            SH_ROR: {r_nxt, c_nxt} = {c, r};
            default: ;
        endcase
    end

endmodule

// File: rtl/jtkcpu_shifter.sv
// Multi-cycle shift/rotate unit, one bit per clock with start/busy/done handshake.
// Define JTKCPU_SHIFT_CLAMP_EN to shorten long counts without changing results.
module jtkcpu_shifter
    import jtkcpu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [7:0]       cnt,
    input  logic [WIDTH-1:0] opnd,
    input  logic [7:0]       cc_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rslt,
    output logic [7:0]       cc_out
);

    sh_state_t        state, state_nxt;
    logic [7:0]       rem;
    logic [7:0]       eff;
    logic             accept;
    logic [2:0]       op_q;
    logic [7:0]       cc_q;
    logic [WIDTH-1:0] r_q, r_nxt;
    logic             c_q, c_nxt;
    logic             v_q, v_nxt;

    function automatic logic [7:0] mk_cc(input logic [7:0] cc, input logic [WIDTH-1:0] r,
                                         input logic c, input logic v);
        mk_cc           = cc;
        mk_cc[CC_C_BIT] = c;
        mk_cc[CC_V_BIT] = v;
        mk_cc[CC_Z_BIT] = (r == '0);
        mk_cc[CC_N_BIT] = r[WIDTH-1];
    endfunction

`ifdef JTKCPU_SHIFT_CLAMP_EN
    localparam logic [7:0] WP1 = 8'(WIDTH + 1);

    // Shifts saturate after WIDTH+1 steps; rotates through C repeat every WIDTH+1.
    always_comb begin
        eff = 8'd0;
        case (op)
            SH_ASL, SH_LSR, SH_ASR: eff = (cnt > WP1) ? WP1 : cnt;
            SH_ROL, SH_ROR:         eff = (cnt == 8'd0) ? 8'd0 : ((cnt - 8'd1) % WP1) + 8'd1;
            default:                eff = 8'd0;
        endcase
    end
`else
    always_comb begin
        eff = 8'd0;
        if (op <= SH_ROR) eff = cnt;
    end
`endif

    jtkcpu_shstep #(.WIDTH(WIDTH)) u_step (
        .op    (op_q),
        .r     (r_q),
        .c     (c_q),
        .v     (v_q),
        .r_nxt (r_nxt),
        .c_nxt (c_nxt),
        .v_nxt (v_nxt)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = (state == ST_SHIFT);
        done      = (state == ST_DONE);
        case (state)
            ST_IDLE, ST_DONE: begin
                accept    = start;
                state_nxt = !start ? ST_IDLE : (eff == 8'd0) ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: if (rem == 8'd1) state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            rem    <= 8'd0;
            rslt   <= '0;
            cc_out <= 8'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rem <= eff;
                if (eff == 8'd0) begin
                    rslt   <= opnd;
                    cc_out <= mk_cc(cc_in, opnd, cc_in[CC_C_BIT], cc_in[CC_V_BIT]);
                end
            end else if (state == ST_SHIFT) begin
                rem <= rem - 8'd1;
                if (rem == 8'd1) begin
                    rslt   <= r_nxt;
                    cc_out <= mk_cc(cc_q, r_nxt, c_nxt, v_nxt);
                end
            end
        end
    end

    // Working registers: only meaningful between an accepted start and done.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= op;
            cc_q <= cc_in;
            r_q  <= opnd;
            c_q  <= cc_in[CC_C_BIT];
            v_q  <= cc_in[CC_V_BIT];
        end else if (state == ST_SHIFT) begin
            r_q <= r_nxt;
            c_q <= c_nxt;
            v_q <= v_nxt;
        end
    end

endmodule
